// File: rtl/chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and default sizing.
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_W = 32;
  localparam int DEF_N = 8;

endpackage

// File: rtl/cla_adder.sv
// N-bit carry-lookahead slice; every carry is expanded from generate/propagate terms.
module cla_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built without rippling through c[i]
  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: one N-bit CLA slice reused K = W/N times, LSB slice first.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | adding slice idx of the latched operands, ready=0
// DONE  | result registered, done pulses, ready=1 (start here chains back-to-back)
module chunk_serial_adder
  import chunk_adder_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         done
);

  localparam int K  = (N > 0) ? (W / N) : 1;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  generate
    if ((N <= 0) || (W <= 0) || (((N > 0) ? (W % N) : 1) != 0)) begin : g_bad_width
      $error("chunk_serial_adder: W must be a positive multiple of N");
    end
  endgenerate

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  work;
  logic [W-1:0]  work_next;
  logic          carry;
  logic [IW-1:0] idx;
  logic [N-1:0]  sl_a;
  logic [N-1:0]  sl_b;
  logic [N-1:0]  sl_s;
  logic          sl_co;
  int            base;

  assign base  = int'(idx) * N;
  assign ready = (state != RUN);

  always_comb begin
    sl_a = a_r[base +: N];
    sl_b = b_r[base +: N];
  end

  always_comb begin
    work_next = work;
    work_next[base +: N] = sl_s;
  end

  cla_adder #(.N(N)) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry),
    .s   (sl_s),
    .cout(sl_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            work  <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= sl_co;
          if (idx == LAST) begin
            sum      <= work_next;
            cout     <= sl_co;
            overflow <= (a_r[W-1] == b_r[W-1]) && (work_next[W-1] != a_r[W-1]);
            done     <= 1'b1;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Scoreboard bench: expected results queued at acceptance, compared when done pulses.
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        reset;

  logic        start32, cin32, ready32, cout32, ovf32, done32;
  logic [31:0] a32, b32, sum32;

  logic        start8, cin8, ready8, cout8, ovf8, done8;
  logic [7:0]  a8, b8, sum8;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int done_cnt32 = 0;
  int done_cnt8 = 0;
  logic [31:0] last_sum32 = '0;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  chunk_serial_adder #(.W(32), .N(8)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .ready(ready32), .sum(sum32), .cout(cout32), .overflow(ovf32), .done(done32)
  );

  chunk_serial_adder #(.W(8), .N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .sum(sum8), .cout(cout8), .overflow(ovf8), .done(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input int w, input int accept_cyc);
    exp_t e;
    logic [32:0] full;
    logic [32:0] mask;
    mask   = (33'd1 << w) - 33'd1;
    full   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, c};
    e.s    = full[31:0] & mask[31:0];
    e.co   = full[w];
    e.ov   = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    e.acc  = accept_cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q32.delete();
      q8.delete();
    end else begin
      if (done32) begin
        done_cnt32++;
        if (q32.size() == 0) chk("done32_unexpected", 1, 0);
        else begin
          e = q32.pop_front();
          chk("sum32", sum32, e.s);
          chk("cout32", cout32, e.co);
          chk("ovf32", ovf32, e.ov);
          chk("lat32", cyc - e.acc, 4);
          last_sum32 = e.s;
        end
      end
      if (done8) begin
        done_cnt8++;
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("sum8", sum8, e.s[7:0]);
          chk("cout8", cout8, e.co);
          chk("ovf8", ovf8, e.ov);
          chk("lat8", cyc - e.acc, 1);
        end
      end
      if (start32 && ready32) q32.push_back(model(a32, b32, cin32, 32, cyc + 1));
      if (start8 && ready8) q8.push_back(model({24'd0, a8}, {24'd0, b8}, cin8, 8, cyc + 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic c);
    int n = 0;
    while (!ready32 && n < 100) begin tick(); n++; end
    start32 = 1'b1; a32 = a; b32 = b; cin32 = c;
    tick();
    start32 = 1'b0;
  endtask

  task automatic drain32();
    int n = 0;
    while (q32.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain32_pending", q32.size(), 0);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain8_pending", q8.size(), 0);
  endtask

  initial begin
    int dc;
    reset = 1'b1;
    start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", ready32, 1);
    chk("rst_sum", sum32, 0);
    chk("rst_cout", cout32, 0);
    chk("rst_ovf", ovf32, 0);
    chk("rst_done", done32, 0);
    chk("rst_ready8", ready8, 1);

    go32(32'h0000_00FF, 32'h0000_0001, 1'b0); drain32();
    chk("carry_into_slice1", sum32, 32'h0000_0100);
    go32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1); drain32();
    chk("full_ripple_cout", cout32, 1);
    go32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); drain32();
    chk("pos_overflow", ovf32, 1);

    // second start arrives while busy and must be ignored
    start32 = 1'b1; a32 = 32'd5; b32 = 32'd6; cin32 = 1'b0;
    tick();
    a32 = 32'h1111_1111; b32 = 32'h1111_1111;
    for (int k = 0; k < 4; k++) begin
      chk("busy_ready", ready32, 0);
      chk("sum_hold", sum32, last_sum32);
      tick();
      start32 = 1'b0;
    end
    chk("done_ready", ready32, 1);
    drain32();
    chk("ignored_start_sum", sum32, 32'h0000_000B);

    // reset while idx==2
    dc = done_cnt32;
    go32(32'h0000_0010, 32'h0000_0020, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", ready32, 1);
    chk("abort_sum", sum32, 0);
    chk("abort_done", done32, 0);
    for (int k = 0; k < 6; k++) tick();
    chk("abort_no_pulse", done_cnt32, dc);
    go32(32'd1, 32'd1, 1'b0); drain32();
    chk("after_abort_sum", sum32, 32'd2);

    for (int i = 0; i < 6; i++) go32($urandom, $urandom, 1'($urandom_range(1)));
    drain32();

    // K=1 instance, with start held high into DONE for a chained operation
    dc = done_cnt8;
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0;
    tick();
    chk("k1_busy_ready", ready8, 0);
    a8 = 8'd3; b8 = 8'd4;
    tick();
    chk("k1_done", done8, 1);
    chk("k1_sum", sum8, 8'd44);
    chk("k1_cout", cout8, 1);
    tick();
    start8 = 1'b0;
    chk("k1_b2b_running", ready8, 0);
    drain8();
    chk("k1_b2b_sum", sum8, 8'd7);
    chk("k1_pulses", done_cnt8 - dc, 2);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
